// File: rtl/mips_pipe_pkg.sv
// Shared pipeline-control types and constants for the MIPS-style core.
package mips_pipe_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned MULDIV_LATENCY_DEFAULT = 4;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of the load currently in EX.
module load_use_detect
    import mips_pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  load_use
);

    logic rs_match;
    logic rt_match;
    logic dest_live;

    // $zero is hardwired, so a load targeting it never creates a dependency
    assign dest_live = ex_mem_read && (ex_rt != REG_ADDR_W'(REG_ZERO));
    assign rs_match  = (ex_rt == id_rs);
    assign rt_match  = id_uses_rt && (ex_rt == id_rt);
    assign load_use  = dest_live && (rs_match || rt_match);

endmodule

// File: rtl/id_exe_hazard_ctrl.sv
// ID/EX hazard controller: load-use stall, branch squash and mul/div occupancy of EX.
// Build option HAZARD_STALL_PERF_EN adds a saturating front-end stall counter.
module id_exe_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned MULDIV_LATENCY = MULDIV_LATENCY_DEFAULT,
    parameter int unsigned REG_ADDR_W     = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  id_muldiv,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_branch_taken,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  idex_hold,
    output logic                  muldiv_busy,
    output logic [15:0]           stall_count
);

    md_state_t  state_q, state_d;
    logic [3:0] md_cnt_q, md_cnt_d;
    logic       load_use;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .load_use    (load_use)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            md_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        muldiv_busy = 1'b0;
        if (reset) begin
            // Keep NOPs flowing into the pipe while reset is held
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        idex_bubble = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        if (id_muldiv) begin
                            state_d  = MD_BUSY;
                            md_cnt_d = 4'(MULDIV_LATENCY - 1);
                        end
                    end
                end
                MD_BUSY: begin
                    idex_hold   = 1'b1;
                    muldiv_busy = 1'b1;
                    md_cnt_d    = md_cnt_q - 4'd1;
                    if (md_cnt_q == 4'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_PERF_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count_q <= 16'd0;
        end else if (!pc_write && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_id_exe_hazard_ctrl.sv
// Directed self-checking bench for id_exe_hazard_ctrl (MULDIV_LATENCY = 4).
module tb_id_exe_hazard_ctrl;

`ifdef HAZARD_STALL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_muldiv;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       ex_branch_taken;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       idex_hold;
    logic       muldiv_busy;
    logic [15:0] stall_count;

    int tests_run;
    int tests_failed;

    id_exe_hazard_ctrl #(
        .MULDIV_LATENCY (4),
        .REG_ADDR_W     (5)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_muldiv       (id_muldiv),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .idex_hold       (idex_hold),
        .muldiv_busy     (muldiv_busy),
        .stall_count     (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Order: pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, muldiv_busy
    task automatic check_outs(input string tag, input logic [5:0] exp);
        check({tag, ".pc_write"},    32'(pc_write),    32'(exp[5]));
        check({tag, ".ifid_write"},  32'(ifid_write),  32'(exp[4]));
        check({tag, ".ifid_flush"},  32'(ifid_flush),  32'(exp[3]));
        check({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(exp[2]));
        check({tag, ".idex_hold"},   32'(idex_hold),   32'(exp[1]));
        check({tag, ".muldiv_busy"}, 32'(muldiv_busy), 32'(exp[0]));
    endtask

    task automatic check_stall(input string tag, input int n);
        check(tag, 32'(stall_count), PERF ? 32'(n) : 32'd0);
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        id_uses_rt      = 1'b0;
        id_muldiv       = 1'b0;
        ex_mem_read     = 1'b0;
        ex_rt           = 5'd0;
        ex_branch_taken = 1'b0;
    endtask

    localparam logic [5:0] IDLE   = 6'b110000;
    localparam logic [5:0] STALL  = 6'b000100;
    localparam logic [5:0] SQUASH = 6'b111100;
    localparam logic [5:0] BUSY   = 6'b000011;
    localparam logic [5:0] IN_RST = 6'b001100;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clear_inputs();
        reset = 1'b1;
        step();
        #1 check_outs("reset_held", IN_RST);
        check_stall("reset_held.stall", 0);
        step();
        reset = 1'b0;
        #1 check_outs("idle", IDLE);
        check_stall("idle.stall", 0);

        // Load-use on rs: exactly one stall cycle
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #1 check_outs("lu_rs", STALL);
        step();
        clear_inputs();
        #1 check_outs("lu_after", IDLE);
        check_stall("lu_after.stall", 1);

        // $zero destination and unused rt never stall
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1 check_outs("lu_zero", IDLE);
        ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
        #1 check_outs("lu_rt_unused", IDLE);
        id_uses_rt = 1'b1;
        #1 check_outs("lu_rt_used", STALL);

        // Branch overrides load-use and mul/div in ID
        ex_branch_taken = 1'b1; id_muldiv = 1'b1;
        #1 check_outs("branch_lu", SQUASH);
        step();
        clear_inputs();
        #1 check_outs("branch_after", IDLE);
        check_stall("branch_after.stall", 1);

        // Mul/div: one advance then three busy cycles, branch ignored
        id_muldiv = 1'b1;
        #1 check_outs("md_issue", IDLE);
        step();
        id_muldiv = 1'b0;
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
        #1 check_outs("md_busy1", BUSY);
        step();
        clear_inputs();
        #1 check_outs("md_busy2", BUSY);
        step();
        #1 check_outs("md_busy3", BUSY);
        step();
        #1 check_outs("md_done", IDLE);
        check_stall("md_done.stall", 4);

        // Reset clears the counter
        reset = 1'b1;
        #1 check_outs("rst_pulse", IN_RST);
        check_stall("rst_pulse.stall", 0);
        step();
        reset = 1'b0;
        #1 check_outs("rst_release", IDLE);

        // Reset in the 2nd busy cycle drops busy at once, no stall survives
        id_muldiv = 1'b1;
        step();
        id_muldiv = 1'b0;
        #1 check_outs("md2_busy1", BUSY);
        step();
        #1 check_outs("md2_busy2", BUSY);
        reset = 1'b1;
        #1 check("md2_rst.muldiv_busy", 32'(muldiv_busy), 32'd0);
        check("md2_rst.idex_hold", 32'(idex_hold), 32'd0);
        step();
        reset = 1'b0;
        #1 check_outs("md2_post_rst", IDLE);
        check_stall("md2_post_rst.stall", 0);
        step();
        #1 check_outs("md2_post_rst2", IDLE);

        // Full 4-cycle mul/div from clean counter
        id_muldiv = 1'b1;
        step();
        id_muldiv = 1'b0;
        step();
        step();
        #1 check_outs("md3_busy3", BUSY);
        step();
        #1 check_outs("md3_done", IDLE);
        check_stall("md3_done.stall", 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
